// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch unit with a small decoupling queue.
//
// Purpose
//   Streams word-aligned instruction reads from fetch_pc, captures each
//   response one cycle after its request and buffers {instr, pc} pairs in a
//   DEPTH-entry circular queue that feeds decode through a valid/ready port.
//   A redirect flushes the queue and the outstanding response, then restarts
//   fetching at the new address on the following cycle.
//
// Ports
//   clk          : only clock, rising edge
//   reset        : synchronous, active-low (0 = reset)
//   imem_req     : instruction read issued this cycle
//   imem_addr    : read address (word aligned)
//   imem_rdata   : read data, valid one cycle after imem_req
//   redirect     : flush and restart at redirect_pc
//   redirect_pc  : new fetch address (low two bits ignored)
//   out_valid    : out_instr / out_pc hold a valid instruction
//   out_ready    : decode accepts the head this cycle
//   out_instr    : head instruction
//   out_pc       : address of the head instruction
//
// Configuration
//   FETCH_QUEUE_BYPASS_EN : when defined, a response that returns while the
//   queue is empty is offered to decode in the same cycle; if accepted it is
//   not written into the queue. Default build (undefined) always goes
//   through the queue.

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   infl_addr_q, infl_addr_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;

  logic [31:0]   ent_instr_q [DEPTH];
  logic [31:0]   ent_instr_d [DEPTH];
  logic [31:0]   ent_pc_q    [DEPTH];
  logic [31:0]   ent_pc_d    [DEPTH];
  logic [DEPTH-1:0] wr_en;

  logic [CW-1:0] used;
  logic          queue_nonempty;
  logic          byp_valid;
  logic          push;
  logic          pop;
  logic          rpc_unused;

  // Low address bits of a redirect target are dropped by the alignment.
  assign rpc_unused = ^redirect_pc[1:0];

  // Credit check on registered state only: queued entries plus the response
  // still in flight must leave room, so a returning response always fits.
  assign used           = count_q + CW'(inflight_q);
  assign imem_req       = reset & ~redirect & (used < DEPTH_C);
  assign imem_addr      = fetch_pc_q;
  assign queue_nonempty = (count_q != '0);

  // Same-cycle forwarding of a response into an empty queue (bypass build).
  assign byp_valid = BYPASS & reset & ~redirect & ~queue_nonempty & inflight_q;

  always_comb begin
    out_valid = 1'b0;
    out_instr = '0;
    out_pc    = '0;
    if (reset) begin
      if (queue_nonempty) begin
        out_valid = 1'b1;
        out_instr = ent_instr_q[head_q];
        out_pc    = ent_pc_q[head_q];
      end else if (byp_valid) begin
        out_valid = 1'b1;
        out_instr = imem_rdata;
        out_pc    = infl_addr_q;
      end
    end
  end

  assign pop  = out_valid & out_ready & queue_nonempty;
  // A response is dropped on redirect, and also when it was taken directly
  // through the bypass path.
  assign push = inflight_q & ~redirect & ~(byp_valid & out_ready);

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    count_d     = count_q;
    inflight_d  = 1'b0;
    infl_addr_d = infl_addr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    if (redirect) begin
      // Any same-cycle pop has already been delivered; everything else goes.
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      inflight_d = 1'b0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d    = count_q + CW'(push) - CW'(pop);
      inflight_d = imem_req;
      if (imem_req) begin
        infl_addr_d = fetch_pc_q;
        fetch_pc_d  = fetch_pc_q + 32'd4;
      end
    end
  end

  // One-hot write enable for the entry at the tail.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (tail_q == AW'(gi));
    end
  endgenerate

  always_comb begin
    ent_instr_d = ent_instr_q;
    ent_pc_d    = ent_pc_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        ent_instr_d[i] = imem_rdata;
        ent_pc_d[i]    = infl_addr_q;
      end
    end
  end

  // Storage contents are only observed after being written, so no reset.
  always_ff @(posedge clk) begin
    ent_instr_q <= ent_instr_d;
    ent_pc_q    <= ent_pc_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q  <= RESET_PC;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      infl_addr_q <= infl_addr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// queue-based behavioural model.

module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state.
  logic [31:0] mq_instr[$];
  logic [31:0] mq_pc[$];
  bit          m_infl = 1'b0;
  logic [31:0] m_infl_addr = '0;
  logic [31:0] m_pc = RESET_PC;

  // Memory side: what the DUT actually asked for last cycle.
  bit          prev_req = 1'b0;
  logic [31:0] prev_addr = '0;

  // Outputs sampled in the most recent cycle.
  bit          s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model across the rising edge.
  task automatic apply(input bit rst, input bit rd, input logic [31:0] rpc, input bit rdy);
    bit          e_req, e_valid, byp, took;
    logic [31:0] e_instr, e_pc;
    reset       = rst;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    imem_rdata  = prev_req ? mem_word(prev_addr) : $urandom;

    e_req   = rst && !rd && ((mq_pc.size() + int'(m_infl)) < DEPTH);
    e_valid = 1'b0;
    byp     = 1'b0;
    e_instr = '0;
    e_pc    = '0;
    if (rst) begin
      if (mq_pc.size() != 0) begin
        e_valid = 1'b1;
        e_instr = mq_instr[0];
        e_pc    = mq_pc[0];
      end else if (BYP && m_infl && !rd) begin
        e_valid = 1'b1;
        byp     = 1'b1;
        e_instr = mem_word(m_infl_addr);
        e_pc    = m_infl_addr;
      end
    end

    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = out_valid;
    s_instr = out_instr;
    s_pc    = out_pc;
    chk("imem_req", 32'(s_req), 32'(e_req));
    if (e_req) chk("imem_addr", s_addr, m_pc);
    chk("out_valid", 32'(s_valid), 32'(e_valid));
    if (e_valid) begin
      chk("out_instr", s_instr, e_instr);
      chk("out_pc", s_pc, e_pc);
    end else if (!rst) begin
      chk("rst_out_instr", s_instr, 32'h0);
      chk("rst_out_pc", s_pc, 32'h0);
    end
    if (s_valid && rdy) $display("deliver pc=%h instr=%h", s_pc, s_instr);
    prev_req  = s_req;
    prev_addr = s_addr;

    @(posedge clk);
    took = e_valid && rdy;
    if (took && !byp) begin
      void'(mq_instr.pop_front());
      void'(mq_pc.pop_front());
    end
    if (!rst) begin
      mq_instr.delete();
      mq_pc.delete();
      m_infl = 1'b0;
      m_pc   = RESET_PC;
    end else if (rd) begin
      mq_instr.delete();
      mq_pc.delete();
      m_infl = 1'b0;
      m_pc   = {rpc[31:2], 2'b00};
    end else begin
      if (m_infl && !(byp && took)) begin
        mq_instr.push_back(mem_word(m_infl_addr));
        mq_pc.push_back(m_infl_addr);
      end
      m_infl      = e_req;
      m_infl_addr = m_pc;
      if (e_req) m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  // Run with out_ready = 1 until an instruction is delivered (bounded).
  task automatic wait_deliv(input int budget, output bit found, output logic [31:0] pc);
    found = 1'b0;
    pc    = '0;
    for (int c = 0; c < budget && !found; c++) begin
      apply(1'b1, 1'b0, 32'h0, 1'b1);
      if (s_valid) begin
        found = 1'b1;
        pc    = s_pc;
      end
    end
  endtask

  initial begin
    bit          f;
    logic [31:0] p;
    int          first;
    logic [31:0] got[$];
    logic [31:0] reqs[$];

    // Reset state.
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    chk("reset_req", 32'(s_req), 32'h0);
    chk("reset_valid", 32'(s_valid), 32'h0);
    chk("reset_pc", s_pc, 32'h0);

    // Reset release with out_ready high.
    first = -1;
    got.delete();
    for (int c = 0; c < 6; c++) begin
      apply(1'b1, 1'b0, 32'h0, 1'b1);
      if (c == 0) chk("rel_c0_addr", s_addr, 32'h0000_3000);
      if (c == 1) chk("rel_c1_addr", s_addr, 32'h0000_3004);
      if (s_valid) begin
        if (first < 0) first = c;
        got.push_back(s_pc);
      end
    end
    chk("rel_first_valid_cycle", 32'(first), BYP ? 32'd1 : 32'd2);
    chk("rel_count", 32'(got.size() >= 3), 32'h1);
    if (got.size() >= 3) begin
      chk("rel_pc0", got[0], 32'h0000_3000);
      chk("rel_pc1", got[1], 32'h0000_3004);
      chk("rel_pc2", got[2], 32'h0000_3008);
    end

    // Backpressure: exactly DEPTH requests, then in-order drain.
    apply(1'b0, 1'b0, 32'h0, 1'b0);
    reqs.delete();
    for (int c = 0; c < 8; c++) begin
      apply(1'b1, 1'b0, 32'h0, 1'b0);
      if (s_req) reqs.push_back(s_addr);
    end
    chk("bp_req_count", 32'(reqs.size()), 32'd4);
    for (int i = 0; i < 4 && i < reqs.size(); i++)
      chk("bp_req_addr", reqs[i], 32'h0000_3000 + 32'(4 * i));
    chk("bp_full_req_low", 32'(s_req), 32'h0);
    got.delete();
    for (int c = 0; c < 10 && got.size() < 4; c++) begin
      apply(1'b1, 1'b0, 32'h0, 1'b1);
      if (s_valid) got.push_back(s_pc);
    end
    chk("bp_drain_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("bp_drain_pc", got[i], 32'h0000_3000 + 32'(4 * i));

    // Redirect with a response in flight.
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    apply(1'b1, 1'b0, 32'h0, 1'b1);
    apply(1'b1, 1'b1, 32'h0000_4003, 1'b1);
    chk("redir_req_low", 32'(s_req), 32'h0);
    chk("redir_valid_low", 32'(s_valid), 32'h0);
    apply(1'b1, 1'b0, 32'h0, 1'b1);
    chk("redir_next_req", 32'(s_req), 32'h1);
    chk("redir_next_addr", s_addr, 32'h0000_4000);
    wait_deliv(8, f, p);
    chk("redir_found", 32'(f), 32'h1);
    chk("redir_first_pc", p, 32'h0000_4000);

    // Redirect coinciding with a pop.
    apply(1'b0, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 3; c++) apply(1'b1, 1'b0, 32'h0, 1'b0);
    apply(1'b1, 1'b1, 32'h0000_5000, 1'b1);
    chk("rpop_valid", 32'(s_valid), 32'h1);
    chk("rpop_pc", s_pc, 32'h0000_3000);
    wait_deliv(8, f, p);
    chk("rpop_found", 32'(f), 32'h1);
    chk("rpop_next_pc", p, 32'h0000_5000);

    // Address wrap-around.
    apply(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    wait_deliv(8, f, p);
    chk("wrap_pc0", p, 32'hFFFF_FFF8);
    wait_deliv(4, f, p);
    chk("wrap_pc1", p, 32'hFFFF_FFFC);
    wait_deliv(4, f, p);
    chk("wrap_pc2", p, 32'h0000_0000);

    // Reset asserted with a full queue.
    for (int c = 0; c < 8; c++) apply(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rfull_valid_before", 32'(s_valid), 32'h1);
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rfull_valid_rst", 32'(s_valid), 32'h0);
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rfull_valid_next", 32'(s_valid), 32'h0);
    apply(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rfull_rel_req", 32'(s_req), 32'h1);
    chk("rfull_rel_addr", s_addr, 32'h0000_3000);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          r_rst, r_rd, r_rdy;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 99) != 0);
      r_rd  = ($urandom_range(0, 15) == 0);
      r_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                          : 32'($urandom);
      r_rdy = ($urandom_range(0, 9) < 7);
      apply(r_rst, r_rd, r_pc, r_rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
